// File: rtl/epl_accumulator.sv
// Early/prompt/late correlator with integrate-and-dump for one tracking channel.
// Six running sums are latched into a holding bank on dump_enable and read via valid/ack.
module epl_accumulator #(
  parameter int SAMPLE_W = 3,
  parameter int ACC_W    = 18
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sample_enable,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [SAMPLE_W-1:0] q_sample,
  input  logic                early,
  input  logic                prompt,
  input  logic                late,
  input  logic                dump_enable,
  input  logic                accum_ack,
  output logic [ACC_W-1:0]    i_early,
  output logic [ACC_W-1:0]    q_early,
  output logic [ACC_W-1:0]    i_prompt,
  output logic [ACC_W-1:0]    q_prompt,
  output logic [ACC_W-1:0]    i_late,
  output logic [ACC_W-1:0]    q_late,
  output logic                accum_valid,
  output logic                accum_overrun
);

  localparam int NUM_ARMS = 3;  // index 0 = early, 1 = prompt, 2 = late

  typedef logic [ACC_W-1:0] acc_t;

  logic [NUM_ARMS-1:0] chip;
  acc_t                i_ext;
  acc_t                q_ext;
  acc_t                sum_i [NUM_ARMS];
  acc_t                sum_q [NUM_ARMS];
  acc_t                acc_i [NUM_ARMS];
  acc_t                acc_q [NUM_ARMS];
  acc_t                dmp_i [NUM_ARMS];
  acc_t                dmp_q [NUM_ARMS];

  assign chip = {late, prompt, early};

  // Sign-extend before negation so the most negative sample negates exactly.
  assign i_ext = {{(ACC_W-SAMPLE_W){i_sample[SAMPLE_W-1]}}, i_sample};
  assign q_ext = {{(ACC_W-SAMPLE_W){q_sample[SAMPLE_W-1]}}, q_sample};

  // Next value of each integrator: the running sum plus this cycle's product
  // when the sample is qualified. Wraps modulo 2^ACC_W.
  always_comb begin
    // NOTE: every element gets a default first, so no path leaves a
    // combinational output unassigned and no latch is inferred.
    for (int k = 0; k < NUM_ARMS; k++) begin
      sum_i[k] = acc_i[k];
      sum_q[k] = acc_q[k];
      if (sample_enable) begin
        sum_i[k] = chip[k] ? acc_i[k] + i_ext : acc_i[k] - i_ext;
        sum_q[k] = chip[k] ? acc_q[k] + q_ext : acc_q[k] - q_ext;
      end
    end
  end

  // Integrators and holding bank. A sample arriving in the dump cycle belongs
  // to the period that is ending, so the dump takes the summed value.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the holding bank is reset alongside the integrators because
    // firmware may read it before the first dump; it is a few flops, not a RAM.
    if (!rstn) begin
      for (int k = 0; k < NUM_ARMS; k++) begin
        acc_i[k] <= '0;
        acc_q[k] <= '0;
        dmp_i[k] <= '0;
        dmp_q[k] <= '0;
      end
    end else if (dump_enable) begin
      // NOTE: non-blocking assignments here; every register reads pre-edge
      // values, so acc clearing and the dump capture do not race.
      for (int k = 0; k < NUM_ARMS; k++) begin
        dmp_i[k] <= sum_i[k];
        dmp_q[k] <= sum_q[k];
        acc_i[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_ARMS; k++) begin
        acc_i[k] <= sum_i[k];
        acc_q[k] <= sum_q[k];
      end
    end
  end

  // Read handshake. A dump into an unacknowledged bank flags overrun but the
  // data is still overwritten (newest wins).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      accum_valid   <= 1'b0;
      accum_overrun <= 1'b0;
    end else if (dump_enable && accum_valid && !accum_ack) begin
      accum_overrun <= 1'b1;
    end else if (dump_enable) begin
      accum_valid <= 1'b1;
    end else if (accum_ack) begin
      accum_valid   <= 1'b0;
      accum_overrun <= 1'b0;
    end
  end

  assign i_early  = dmp_i[0];
  assign q_early  = dmp_q[0];
  assign i_prompt = dmp_i[1];
  assign q_prompt = dmp_q[1];
  assign i_late   = dmp_i[2];
  assign q_late   = dmp_q[2];

endmodule

// File: tb/tb_epl_accumulator.sv
// Directed bench for epl_accumulator: hand-computed dump values and handshake flags.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_epl_accumulator;

  localparam int SAMPLE_W = 3;
  localparam int ACC_W    = 18;

  logic                clk = 1'b0;
  logic                rstn;
  logic                sample_enable;
  logic [SAMPLE_W-1:0] i_sample;
  logic [SAMPLE_W-1:0] q_sample;
  logic                early;
  logic                prompt;
  logic                late;
  logic                dump_enable;
  logic                accum_ack;
  logic [ACC_W-1:0]    i_early;
  logic [ACC_W-1:0]    q_early;
  logic [ACC_W-1:0]    i_prompt;
  logic [ACC_W-1:0]    q_prompt;
  logic [ACC_W-1:0]    i_late;
  logic [ACC_W-1:0]    q_late;
  logic                accum_valid;
  logic                accum_overrun;

  int checks = 0;
  int errors = 0;

  logic [ACC_W-1:0] outs  [6];
  logic [ACC_W-1:0] exp_v [6];
  string            names [6] = '{"i_early", "q_early", "i_prompt", "q_prompt", "i_late", "q_late"};

  assign outs[0] = i_early;
  assign outs[1] = q_early;
  assign outs[2] = i_prompt;
  assign outs[3] = q_prompt;
  assign outs[4] = i_late;
  assign outs[5] = q_late;

  epl_accumulator #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .sample_enable(sample_enable),
    .i_sample     (i_sample),
    .q_sample     (q_sample),
    .early        (early),
    .prompt       (prompt),
    .late         (late),
    .dump_enable  (dump_enable),
    .accum_ack    (accum_ack),
    .i_early      (i_early),
    .q_early      (q_early),
    .i_prompt     (i_prompt),
    .q_prompt     (q_prompt),
    .i_late       (i_late),
    .q_late       (q_late),
    .accum_valid  (accum_valid),
    .accum_overrun(accum_overrun)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; returns 1 ns after the edge with strobes cleared.
  task automatic drive(input logic se, input logic [SAMPLE_W-1:0] i, input logic [SAMPLE_W-1:0] q,
                       input logic e, input logic p, input logic l, input logic dmp, input logic ack);
    sample_enable = se;
    i_sample      = i;
    q_sample      = q;
    early         = e;
    prompt        = p;
    late          = l;
    dump_enable   = dmp;
    accum_ack     = ack;
    @(posedge clk);
    #1;
    sample_enable = 1'b0;
    dump_enable   = 1'b0;
    accum_ack     = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    sample_enable = 1'b0; i_sample = '0; q_sample = '0;
    early = 1'b0; prompt = 1'b0; late = 1'b0;
    dump_enable = 1'b0; accum_ack = 1'b0;
    #12;
    for (int k = 0; k < 6; k++) exp_v[k] = '0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (outs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL reset_%s: got %0d expected %0d", names[k], $signed(outs[k]), $signed(exp_v[k]));
      end
    end
    checks++;
    if (accum_valid !== 1'b0 || accum_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b overrun=%b expected 0 0", accum_valid, accum_overrun);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_basic;
    for (int n = 1; n <= 100; n++) begin
      if (n == 100) begin
        checks++;
        if (accum_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_valid_before_dump: got %b expected 0", accum_valid);
        end
      end
      drive(1'b1, 3'b001, 3'b111, 1'b1, 1'b1, 1'b1, n == 100, 1'b0);
    end
    exp_v = '{18'sd100, -18'sd100, 18'sd100, -18'sd100, 18'sd100, -18'sd100};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (outs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL basic_%s: got %0d expected %0d", names[k], $signed(outs[k]), $signed(exp_v[k]));
      end
    end
    checks++;
    if (accum_valid !== 1'b1 || accum_overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: got valid=%b overrun=%b expected 1 0", accum_valid, accum_overrun);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (accum_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack_clears_valid: got %b expected 0", accum_valid);
    end
  endtask

  task automatic test_full_period;
    for (int n = 1; n <= 16368; n++)
      drive(1'b1, 3'b100, 3'b000, 1'b1, 1'b0, 1'b1, n == 16368, 1'b0);
    exp_v = '{-18'sd65472, 18'sd0, 18'sd65472, 18'sd0, -18'sd65472, 18'sd0};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (outs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL full_%s: got %0d expected %0d", names[k], $signed(outs[k]), $signed(exp_v[k]));
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun;
    for (int n = 1; n <= 5; n++)
      drive(1'b1, 3'b001, 3'b001, 1'b1, 1'b1, 1'b1, n == 5, 1'b0);
    checks++;
    if (accum_valid !== 1'b1 || accum_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first_flags: got valid=%b overrun=%b expected 1 0", accum_valid, accum_overrun);
    end
    // Second period: I=+2, Q=-1, all chips 0 -> I sums -6, Q sums +3.
    for (int n = 1; n <= 3; n++)
      drive(1'b1, 3'b010, 3'b111, 1'b0, 1'b0, 1'b0, n == 3, 1'b0);
    checks++;
    if (accum_valid !== 1'b1 || accum_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second_flags: got valid=%b overrun=%b expected 1 1", accum_valid, accum_overrun);
    end
    exp_v = '{-18'sd6, 18'sd3, -18'sd6, 18'sd3, -18'sd6, 18'sd3};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (outs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL ovr_%s: got %0d expected %0d", names[k], $signed(outs[k]), $signed(exp_v[k]));
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (accum_valid !== 1'b0 || accum_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_ack_flags: got valid=%b overrun=%b expected 0 0", accum_valid, accum_overrun);
    end
    checks++;
    if (i_early !== 18'h3fffa) begin
      errors++;
      $display("FAIL ovr_hold_after_ack: got %0d expected -6", $signed(i_early));
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 1; n <= 2; n++)
      drive(1'b1, 3'b001, 3'b001, 1'b1, 1'b1, 1'b1, n == 2, 1'b0);
    checks++;
    if (i_prompt !== 18'd2 || accum_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got i_prompt=%0d valid=%b expected 2 1", $signed(i_prompt), accum_valid);
    end
    // Dump and ack together right after a dump: only this cycle's products.
    drive(1'b1, 3'b011, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_v = '{18'sd3, 18'sd1, -18'sd3, -18'sd1, 18'sd3, 18'sd1};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (outs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL b2b_%s: got %0d expected %0d", names[k], $signed(outs[k]), $signed(exp_v[k]));
      end
    end
    checks++;
    if (accum_valid !== 1'b1 || accum_overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack_dump_flags: got valid=%b overrun=%b expected 1 0", accum_valid, accum_overrun);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_gated;
    for (int c = 0; c < 20; c++)
      drive(c % 2 == 0, 3'b011, 3'b000, 1'b1, 1'b0, 1'b1, c == 19, 1'b0);
    exp_v = '{18'sd30, 18'sd0, -18'sd30, 18'sd0, 18'sd30, 18'sd0};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (outs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL gated_%s: got %0d expected %0d", names[k], $signed(outs[k]), $signed(exp_v[k]));
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    // Leave valid and overrun set so the reset has something to clear.
    drive(1'b1, 3'b001, 3'b001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 3'b001, 3'b001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (accum_overrun !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre_overrun: got %b expected 1", accum_overrun);
    end
    for (int n = 1; n <= 50; n++)
      drive(1'b1, 3'b001, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rstn = 1'b0;
    #2;
    checks++;
    if (accum_valid !== 1'b0 || accum_overrun !== 1'b0 || i_prompt !== 18'd0) begin
      errors++;
      $display("FAIL rmid_async_clear: got valid=%b overrun=%b i_prompt=%0d expected 0 0 0",
               accum_valid, accum_overrun, $signed(i_prompt));
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int n = 1; n <= 10; n++)
      drive(1'b1, 3'b010, 3'b000, 1'b0, 1'b1, 1'b1, n == 10, 1'b0);
    exp_v = '{-18'sd20, 18'sd0, 18'sd20, 18'sd0, 18'sd20, 18'sd0};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (outs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL rmid_%s: got %0d expected %0d", names[k], $signed(outs[k]), $signed(exp_v[k]));
      end
    end
    checks++;
    if (accum_valid !== 1'b1 || accum_overrun !== 1'b0) begin
      errors++;
      $display("FAIL rmid_flags: got valid=%b overrun=%b expected 1 0", accum_valid, accum_overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_period();
    test_overrun();
    test_back_to_back();
    test_gated();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/epl_accumulator.md
# epl_accumulator

Per-channel early/prompt/late correlator and integrate-and-dump stage sitting directly downstream of `code_gen` in each tracking channel. Multiplies carrier-wiped I and Q baseband samples by the early, prompt and late C/A chips, integrates six sums over one code period, and latches them into a holding bank on each `dump_enable` pulse. The holding bank is read by the tracking-loop firmware through a valid/ack handshake with overrun detection.

## Interface
- `SAMPLE_W`, 3: width of signed two's-complement I/Q input samples.
- `ACC_W`, 18: width of each signed accumulator and dump register.

- `clk`  in  1  system clock, 16.368 MHz nominal
- `rstn`  in  1  asynchronous active-low reset
- `sample_enable`  in  1  qualifies `i_sample`/`q_sample` for this cycle
- `i_sample`  in  SAMPLE_W  signed in-phase carrier-wiped sample
- `q_sample`  in  SAMPLE_W  signed quadrature carrier-wiped sample
- `early`, `prompt`, `late`  in  1 each  code chips from `code_gen`; 1 -> +1, 0 -> -1
- `dump_enable`  in  1  single-cycle end-of-integration pulse from `code_gen`
- `accum_ack`  in  1  single-cycle read acknowledge from bus interface
- `i_early`, `q_early`, `i_prompt`, `q_prompt`, `i_late`, `q_late`  out  ACC_W each  latched integration results, signed
- `accum_valid`  out  1  new dump results available
- `accum_overrun`  out  1  a dump overwrote unacknowledged results

## Operation
- Products: for each arm X in {E,P,L}, `pI_X = chip_X ? i_sample : -i_sample`, same for Q; sign-extend to ACC_W before negation so -(-2^(SAMPLE_W-1)) is exact.
- Six running accumulators `acc_*`, ACC_W signed, modular two's-complement wrap, no saturation.
- Cycle with `sample_enable`=1, `dump_enable`=0: `acc_* <= acc_* + p_*`.
- Cycle with `sample_enable`=0, `dump_enable`=0: accumulators hold.
- Cycle with `dump_enable`=1: dump registers `<= acc_* + (sample_enable ? p_* : 0)` (sample in the dump cycle belongs to the ending period); `acc_* <= 0`.
- Dump registers hold between dumps; only changed by a dump or reset.
- Handshake flags (priority top-down, evaluated each cycle):
  - dump and `accum_valid`=1 and no ack: `accum_valid` stays 1, `accum_overrun <= 1`.
  - dump (valid=0, or ack in same cycle): `accum_valid <= 1`, overrun unchanged by this case unless it was set earlier.
  - ack without dump: `accum_valid <= 0`, `accum_overrun <= 0`.
  - else hold.
- Ack while `accum_valid`=0: no effect except clearing `accum_overrun`.
- Dump register update is independent of handshake state; overrun still overwrites data (newest wins).

## Timing
- Reset (async assert, sync-released by system): all accumulators, dump registers, `accum_valid`, `accum_overrun` = 0.
- Reset mid-integration discards partial sums; first dump after reset covers only samples since release.
- All outputs registered; results and `accum_valid` visible the cycle after the `dump_enable` edge (latency 1 clk).
- Chip inputs sampled in the same cycle as their sample; no internal realignment of early/prompt/late.
- One sample accumulated per cycle max; back-to-back `dump_enable` pulses allowed (second dump gives that cycle's products only).
- Full-period magnitude bound: 16368 samples x 4 = 65472 < 2^17; ACC_W=18 never wraps at nominal rate.

## Test plan
- Reset, then 100 samples I=+1, Q=-1, all chips 1, dump on sample 100 -> `i_*`=+100, `q_*`=-100, `accum_valid`=1 one cycle after dump.
- 16368 samples I=-4 with prompt=0, early=1, late=1, dump at last sample -> `i_prompt`=+65472, `i_early`=`i_late`=-65472, no wrap.
- Two dumps with no `accum_ack` between -> second dump sets `accum_overrun`=1, registers hold second-period values; `accum_ack` clears both flags next cycle.
- `accum_ack` and `dump_enable` same cycle with valid=1 -> `accum_valid` stays 1, `accum_overrun` stays 0.
- `sample_enable`=0 on alternate cycles over 20 cycles, I=+3 -> dump gives `i_*` = ±30 per chip polarity; gated cycles add nothing.
- Assert `rstn`=0 after 50 accumulated samples, release, 10 samples I=+2, dump -> `i_prompt`=+20 (chip 1), flags cleared by reset.
